reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//   Consumes the synchronised active-high reset from the async reset controller and releases a bank
//   of per-domain resets in a fixed order, each held for a set number of cycles.
//   Stage 0 releases first (e.g. baud gen), then UART core, then the host interface.
//   Provides a soft-reset request/ack handshake and an optional watchdog that replays the sequence.
// PARAMETERS
//   STAGES      3   number of staged reset outputs (1..8)
//   HOLD_CYCLES 16  clock cycles between successive stage releases (>=1)
//   CNT_WIDTH   5   hold counter width; must represent HOLD_CYCLES-1
//   WDT_WIDTH   16  watchdog counter width (used only with RESET_SEQ_WDT_EN)
// PORTS
//   clk          in   1       system clock
//   reset        in   1       async assert, active high; driven by the sync reset controller
//   soft_req     in   1       level soft-reset request, held until soft_ack
//   soft_ack     out  1       one-cycle pulse: request accepted
//   stage_reset  out  STAGES  per-domain reset, active high; bit 0 releases first
//   ready        out  1       high when all stages are released (state RUN)
//   wdt_kick     in   1       watchdog kick pulse; ignored without RESET_SEQ_WDT_EN
//   wdt_fired    out  1       sticky: the watchdog caused a sequence; tied 0 without the macro
// BEHAVIOUR
//   - Reset is asynchronous and active-high. While reset=1:
//     state=HOLD, cnt=0, stg=0, stage_reset='1, ready=0, soft_ack=0, armed=1, wdt_cnt=0, wdt_fired=0.
//   - FSM: HOLD -> RELEASE -> RUN; RUN -> HOLD on an accepted soft request or a watchdog expiry.
//   - HOLD: cnt increments each edge. At cnt==HOLD_CYCLES-1: cnt<=0, stage_reset[0]<=0,
//     stg<=1, go to RELEASE (or RUN if STAGES==1).
//   - RELEASE: cnt increments. At cnt==HOLD_CYCLES-1: stage_reset[stg]<=0, cnt<=0, stg++.
//     When the last stage is released, go to RUN and set ready<=1 on the same edge.
//   - Timing: counting edges from the first rising edge after reset falls as edge 1,
//     stage_reset[k] falls at edge (k+1)*HOLD_CYCLES and ready rises at edge STAGES*HOLD_CYCLES.
//   - stage_reset bits only ever fall in ascending order, one per release event.
//     A released stage never re-asserts except via HOLD entry, which sets all bits on one edge.
//   - Soft request: accepted only in RUN with armed=1 and soft_req=1. On the next edge:
//     stage_reset<='1, ready<=0, cnt<=0, stg<=0, state<=HOLD, soft_ack<=1 for one cycle, armed<=0.
//   - armed re-sets on any edge where soft_req=0. A held request therefore fires exactly once.
//   - A request in HOLD or RELEASE is neither acked nor queued. It is accepted in RUN if still held.
//   - A soft request and a watchdog expiry on the same cycle form one event:
//     a single sequence restart, soft_ack pulses, and wdt_fired is also set.
//   - Async reset mid-sequence or mid-request overrides everything immediately. No ack is issued.
//   - No combinational path from any input to any output; all outputs are registered.
// CONFIGURATION
//   RESET_SEQ_WDT_EN defined:
//     - wdt_cnt counts only in RUN. wdt_kick=1 clears it to 0.
//     - wdt_cnt is held at 0 outside RUN.
//     - When wdt_cnt reaches all-ones (2^WDT_WIDTH-1) with no kick that cycle, the next edge
//       performs HOLD entry like a soft reset (no soft_ack) and sets wdt_fired=1.
//     - wdt_fired stays 1 until async reset.
//   RESET_SEQ_WDT_EN undefined:
//     - No watchdog logic. wdt_kick is unused and wdt_fired is constant 0.
// TESTING
//   1. Defaults; reset high 5 cycles then low -> stage_reset=111 until edge 16, 110 at 16,
//      100 at 32, 000 at 48; ready rises at edge 48.
//   2. In RUN, soft_req held high 100 cycles -> one soft_ack pulse on the edge after the first
//      sample, stage_reset=111, ready=0, sequence restarts, no second ack.
//   3. soft_req pulsed at edge 20 (RELEASE) -> no ack, sequence continues unchanged to ready at 48.
//   4. Reset reasserted at edge 25 -> stage_reset=111 and ready=0 immediately (asynchronously);
//      after release, full 48-cycle sequence.
//   5. With RESET_SEQ_WDT_EN and WDT_WIDTH=4, no kicks in RUN -> restart after 16 RUN cycles,
//      wdt_fired=1 sticky. Kicks every 10 cycles -> never fires.
//   6. HOLD_CYCLES=1, STAGES=1 -> stage_reset and ready toggle at edge 1. Param sweep STAGES=8:
//      releases strictly ascending.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Takes the synchronised active-high reset from the reset controller and
// releases a bank of per-domain resets one after another. Each stage is held
// for HOLD_CYCLES clocks after the previous one. Bit 0 is released first
// (baud generator), then the UART core, then the host interface. A level
// soft-reset request with a one-cycle acknowledge replays the whole sequence.
//
// Optional feature (compile-time macro RESET_SEQ_WDT_EN):
//   A watchdog counts cycles spent in RUN and is cleared by wdt_kick. If the
//   counter reaches all-ones with no kick on that cycle, the sequence is
//   replayed and the sticky wdt_fired flag is set. Without the macro there is
//   no watchdog logic, wdt_kick is ignored and wdt_fired is tied to 0.
//
// Parameters
//   STAGES       number of staged reset outputs (1..8)
//   HOLD_CYCLES  clocks between successive stage releases (>=1)
//   CNT_WIDTH    hold counter width, must represent HOLD_CYCLES-1
//   WDT_WIDTH    watchdog counter width (watchdog build only)
//
// Ports
//   clk          system clock
//   reset        asynchronous assert, active high
//   soft_req     level soft-reset request, held until soft_ack
//   soft_ack     one-cycle pulse, request accepted
//   stage_reset  per-domain resets, active high, bit 0 releases first
//   ready        high when every stage is released (state RUN)
//   wdt_kick     watchdog kick pulse
//   wdt_fired    sticky flag, the watchdog caused a sequence replay
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int STAGES      = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_WIDTH   = 5,
  parameter int WDT_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              soft_req,
  output logic              soft_ack,
  output logic [STAGES-1:0] stage_reset,
  output logic              ready,
  input  logic              wdt_kick,
  output logic              wdt_fired
);

  // stg must reach STAGES after the final release.
  localparam int STG_W = $clog2(STAGES + 1);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [STG_W-1:0]     STG_LAST = STG_W'(STAGES - 1);
  localparam logic [STG_W-1:0]     STG_ONE  = STG_W'(1);

  // Elaboration-time parameter sanity.
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("reset_sequencer: STAGES must be in 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if ((HOLD_CYCLES - 1) >= (1 << CNT_WIDTH)) begin : g_bad_cnt
    $error("reset_sequencer: CNT_WIDTH too small for HOLD_CYCLES-1");
  end

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [STG_W-1:0]     stg;
  logic                 armed;

  logic                 soft_take;
  logic                 wdt_expire;
  logic                 restart;

  // A request is honoured only once per assertion: armed drops on accept and
  // comes back only after soft_req has been seen low.
  assign soft_take = (state == ST_RUN) && armed && soft_req;
  assign restart   = soft_take || wdt_expire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      stg         <= '0;
      stage_reset <= '1;
      ready       <= 1'b0;
      soft_ack    <= 1'b0;
      armed       <= 1'b1;
    end else begin
      soft_ack <= 1'b0;
      if (!soft_req) begin
        armed <= 1'b1;
      end

      if (restart) begin
        // Soft request and watchdog expiry on the same cycle collapse into
        // a single replay; the ack still goes out for the soft request.
        state       <= ST_HOLD;
        cnt         <= '0;
        stg         <= '0;
        stage_reset <= '1;
        ready       <= 1'b0;
        soft_ack    <= soft_take;
        if (soft_take) begin
          armed <= 1'b0;
        end
      end else begin
        case (state)
          ST_HOLD: begin
            if (cnt == CNT_LAST) begin
              cnt         <= '0;
              // Shifting in zeros from the bottom releases bit 0 first and
              // guarantees releases only ever proceed in ascending order.
              stage_reset <= stage_reset << 1;
              stg         <= STG_ONE;
              if (STAGES == 1) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end else begin
                state <= ST_RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_RELEASE: begin
            if (cnt == CNT_LAST) begin
              cnt         <= '0;
              stage_reset <= stage_reset << 1;
              stg         <= stg + 1'b1;
              if (stg == STG_LAST) begin
                state <= ST_RUN;
                ready <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end

          ST_RUN: begin
            // Steady state; left only through restart.
          end

          default: begin
            state       <= ST_HOLD;
            cnt         <= '0;
            stg         <= '0;
            stage_reset <= '1;
            ready       <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef RESET_SEQ_WDT_EN
  logic [WDT_WIDTH-1:0] wdt_cnt;

  assign wdt_expire = (state == ST_RUN) && (wdt_cnt == '1) && !wdt_kick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      // Counter only runs while in RUN and restarts from zero on any replay.
      if (state != ST_RUN || restart || wdt_kick) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
      if (wdt_expire) begin
        wdt_fired <= 1'b1;
      end
    end
  end
`else
  // Watchdog absent: the kick input is intentionally dropped.
  logic [WDT_WIDTH-1:0] unused_wdt;
  assign unused_wdt = {WDT_WIDTH{wdt_kick}};
  assign wdt_expire = 1'b0;
  assign wdt_fired  = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic soft_req = 1'b0;
  logic wdt_kick = 1'b0;

  always #5 clk = ~clk;

`ifdef RESET_SEQ_WDT_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  // Four configurations sharing the same stimulus.
  logic [2:0] sr0; logic rdy0, ack0, wf0;
  logic [0:0] sr1; logic rdy1, ack1, wf1;
  logic [7:0] sr2; logic rdy2, ack2, wf2;
  logic [2:0] sr3; logic rdy3, ack3, wf3;

  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .CNT_WIDTH(5), .WDT_WIDTH(16)) u0 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack0),
    .stage_reset(sr0), .ready(rdy0), .wdt_kick(wdt_kick), .wdt_fired(wf0));
  reset_sequencer #(.STAGES(1), .HOLD_CYCLES(1), .CNT_WIDTH(1), .WDT_WIDTH(16)) u1 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack1),
    .stage_reset(sr1), .ready(rdy1), .wdt_kick(wdt_kick), .wdt_fired(wf1));
  reset_sequencer #(.STAGES(8), .HOLD_CYCLES(3), .CNT_WIDTH(2), .WDT_WIDTH(16)) u2 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack2),
    .stage_reset(sr2), .ready(rdy2), .wdt_kick(wdt_kick), .wdt_fired(wf2));
  reset_sequencer #(.STAGES(3), .HOLD_CYCLES(16), .CNT_WIDTH(5), .WDT_WIDTH(4)) u3 (
    .clk(clk), .reset(reset), .soft_req(soft_req), .soft_ack(ack3),
    .stage_reset(sr3), .ready(rdy3), .wdt_kick(wdt_kick), .wdt_fired(wf3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic int s_of(input int i);
    case (i) 0: return 3; 1: return 1; 2: return 8; default: return 3; endcase
  endfunction
  function automatic int h_of(input int i);
    case (i) 0: return 16; 1: return 1; 2: return 3; default: return 16; endcase
  endfunction
  function automatic int wmax_of(input int i);
    case (i) 3: return 15; default: return 65535; endcase
  endfunction

  // Model: t = edges since the sequence (re)started. Stage k is held while
  // t < (k+1)*H; all stages are out (RUN) once t >= S*H.
  int m_t     [4];
  int m_w     [4];
  bit m_armed [4];
  bit m_ack   [4];
  bit m_fired [4];

  function automatic bit in_run(input int i);
    return m_t[i] >= s_of(i) * h_of(i);
  endfunction
  function automatic bit soft_fire(input int i);
    return in_run(i) && m_armed[i] && soft_req;
  endfunction
  function automatic bit wdt_fire(input int i);
    return WDT_EN && in_run(i) && (m_w[i] == wmax_of(i)) && !wdt_kick;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_t[i] <= 0; m_w[i] <= 0; m_armed[i] <= 1'b1; m_ack[i] <= 1'b0; m_fired[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_ack[i]   <= soft_fire(i);
        m_armed[i] <= !soft_req ? 1'b1 : (soft_fire(i) ? 1'b0 : m_armed[i]);
        if (soft_fire(i) || wdt_fire(i)) begin
          m_t[i] <= 0;
          m_w[i] <= 0;
        end else begin
          m_t[i] <= (m_t[i] < 100000) ? m_t[i] + 1 : m_t[i];
          m_w[i] <= (!in_run(i) || wdt_kick) ? 0 : m_w[i] + 1;
        end
        if (wdt_fire(i)) m_fired[i] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] exp_sr(input int i);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < s_of(i); k++) r[k] = (m_t[i] < (k + 1) * h_of(i));
    return r;
  endfunction

  function automatic logic [31:0] act_sr(input int i);
    case (i)
      0: return {29'd0, sr0};
      1: return {31'd0, sr1};
      2: return {24'd0, sr2};
      default: return {29'd0, sr3};
    endcase
  endfunction
  function automatic logic [3:0] act_flags(input int i); // {ready, ack, fired, 0}
    case (i)
      0: return {rdy0, ack0, wf0, 1'b0};
      1: return {rdy1, ack1, wf1, 1'b0};
      2: return {rdy2, ack2, wf2, 1'b0};
      default: return {rdy3, ack3, wf3, 1'b0};
    endcase
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (n_checks >= 0 && $time > 2) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("model stage_reset u%0d", i), act_sr(i), exp_sr(i));
        chk($sformatf("model flags u%0d", i), {28'd0, act_flags(i)},
            {28'd0, in_run(i), m_ack[i], m_fired[i], 1'b0});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  int acks;

  initial begin
    #1 reset = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    // Power-up sequence, literal edge times.
    step(1);
    chk("u1 released at edge 1", {31'd0, sr1}, 32'd0);
    chk("u1 ready at edge 1", {31'd0, rdy1}, 32'd1);
    chk("u0 held at edge 1", {29'd0, sr0}, 32'h7);
    step(8);
    chk("u2 at edge 9", {24'd0, sr2}, 32'hF8);
    step(6);
    chk("u0 at edge 15", {29'd0, sr0}, 32'h7);
    chk("u0 not ready edge 15", {31'd0, rdy0}, 32'd0);
    step(1);
    chk("u0 at edge 16", {29'd0, sr0}, 32'h6);
    step(8);
    chk("u2 at edge 24", {24'd0, sr2}, 32'h00);
    chk("u2 ready edge 24", {31'd0, rdy2}, 32'd1);
    step(8);
    chk("u0 at edge 32", {29'd0, sr0}, 32'h4);
    step(15);
    chk("u0 not ready edge 47", {31'd0, rdy0}, 32'd0);
    step(1);
    chk("u0 at edge 48", {29'd0, sr0}, 32'h0);
    chk("u0 ready edge 48", {31'd0, rdy0}, 32'd1);

    // Watchdog without kicks (u3, 4-bit counter): replay after 16 RUN cycles.
    step(15);
    chk("u3 ready edge 63", {31'd0, rdy3}, 32'd1);
    chk("u3 fired edge 63", {31'd0, wf3}, 32'd0);
    step(1);
    chk("u3 ready edge 64", {31'd0, rdy3}, {31'd0, !WDT_EN});
    chk("u3 fired edge 64", {31'd0, wf3}, {31'd0, WDT_EN});
    chk("u0 wdt_fired", {31'd0, wf0}, 32'd0);

    // Held soft request: exactly one ack.
    step(2);
    soft_req = 1'b1;
    step(1);
    chk("u0 soft_ack", {31'd0, ack0}, 32'd1);
    chk("u0 restart sr", {29'd0, sr0}, 32'h7);
    chk("u0 restart ready", {31'd0, rdy0}, 32'd0);
    acks = 0;
    for (int c = 0; c < 99; c++) begin
      step(1);
      acks += int'(ack0);
    end
    soft_req = 1'b0;
    chk("u0 no second ack", acks, 0);
    chk("u0 ready after replay", {31'd0, rdy0}, 32'd1);

    // Request during RELEASE is dropped.
    do_reset();
    step(20);
    soft_req = 1'b1;
    acks = 0;
    step(1);
    soft_req = 1'b0;
    acks += int'(ack0);
    for (int c = 0; c < 27; c++) begin
      step(1);
      acks += int'(ack0);
    end
    chk("u0 no ack in RELEASE", acks, 0);
    chk("u0 ready edge 48 after pulse", {31'd0, rdy0}, 32'd1);
    chk("u0 sr edge 48 after pulse", {29'd0, sr0}, 32'h0);

    // Asynchronous reset mid-sequence.
    do_reset();
    step(25);
    reset = 1'b1;
    #1;
    chk("u0 async sr", {29'd0, sr0}, 32'h7);
    chk("u0 async ready", {31'd0, rdy0}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step(47);
    chk("u0 not ready edge 47 after async", {31'd0, rdy0}, 32'd0);
    step(1);
    chk("u0 ready edge 48 after async", {31'd0, rdy0}, 32'd1);

    // Regular kicks keep the watchdog quiet.
    do_reset();
    for (int c = 0; c < 200; c++) begin
      wdt_kick = (c % 10 == 0);
      step(1);
    end
    wdt_kick = 1'b0;
    chk("u3 kicked never fires", {31'd0, wf3}, 32'd0);
    chk("u3 kicked stays ready", {31'd0, rdy3}, 32'd1);

    step(1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
